// File: rtl/fpga9685_pkg.sv
// Shared constants and types for the fpga9685 PWM path: register map,
// bit positions within the mode and LEDn_H registers, and the channel shadow.
package fpga9685_pkg;

    localparam int MODE1     = 0;
    localparam int MODE2     = 1;
    localparam int LED0_ON_L = 6;

    localparam int SLEEP = 4;
    localparam int INVRT = 4;
    localparam int FULL  = 4;

    localparam int                     COUNTER_WIDTH = 12;
    localparam logic [COUNTER_WIDTH-1:0] COUNTER_MAX = 12'hFFF;

    typedef struct packed {
        logic [COUNTER_WIDTH-1:0] on;
        logic [COUNTER_WIDTH-1:0] off;
        logic                     full_on;
        logic                     full_off;
    } shadow_t;

    // A cleared channel is held fully off until the first wrap reloads it.
    localparam shadow_t SHADOW_RESET = '{on: '0, off: '0, full_on: 1'b0, full_off: 1'b1};

    function automatic shadow_t decode_shadow(input logic [7:0] on_l, input logic [7:0] on_h,
                                              input logic [7:0] off_l, input logic [7:0] off_h);
        shadow_t s;
        s.on       = {on_h[3:0], on_l};
        s.off      = {off_h[3:0], off_l};
        s.full_on  = on_h[FULL];
        s.full_off = off_h[FULL];
        return s;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: wrap-loaded shadow of the ON/OFF registers and the
// combinational level decision against the sampled period counter.
module pwm_channel
    import fpga9685_pkg::*;
(
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [7:0]               on_l_i,
    input  logic [7:0]               on_h_i,
    input  logic [7:0]               off_l_i,
    input  logic [7:0]               off_h_i,
    input  logic                     wrap_i,
    input  logic [COUNTER_WIDTH-1:0] cnt_i,
    output logic                     level_o
);

    shadow_t shadow_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            shadow_q <= SHADOW_RESET;
        end else if (wrap_i) begin
            shadow_q <= decode_shadow(on_l_i, on_h_i, off_l_i, off_h_i);
        end
    end

    // Rule order matters: full_off beats full_on, and equal ON/OFF means never on.
    always_comb begin
        level_o = 1'b0;
        if (shadow_q.full_off) begin
            level_o = 1'b0;
        end else if (shadow_q.full_on) begin
            level_o = 1'b1;
        end else if (shadow_q.on == shadow_q.off) begin
            level_o = 1'b0;
        end else if (shadow_q.on < shadow_q.off) begin
            level_o = (cnt_i >= shadow_q.on) && (cnt_i < shadow_q.off);
        end else begin
            level_o = (cnt_i >= shadow_q.on) || (cnt_i < shadow_q.off);
        end
    end

    logic unused_hi;
    assign unused_hi = ^{on_h_i[7:5], off_h_i[7:5]};

endmodule

// File: rtl/pwm_channel_bank.sv
// PCA9685-style PWM output stage: detects the 4095->0 period wrap, drives
// NUM_CHANNELS shadowed channels and applies invert / sleep / output-enable.
module pwm_channel_bank
    import fpga9685_pkg::*;
#(
    parameter int         NUM_CHANNELS = 16,
    parameter logic [7:0] BASE_REG     = 8'h06
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [0:2047]            register_blob_i,
    input  logic [COUNTER_WIDTH-1:0] counter_i,
    input  logic                     oe_ni,
    output logic [NUM_CHANNELS-1:0]  pwm_o,
    output logic                     period_start_o
);

    logic [COUNTER_WIDTH-1:0] cnt_q;
    logic                     wrap;
    logic [NUM_CHANNELS-1:0]  raw_level;
    logic [NUM_CHANNELS-1:0]  final_level;
    logic                     invrt;
    logic                     sleep;

    assign wrap = (cnt_q == COUNTER_MAX) && (counter_i == '0);

    // Byte k is MSB-first at blob bits 8k..8k+7, so bit b sits at 8k + 7 - b.
    assign invrt = register_blob_i[8*MODE2 + 7 - INVRT];
    assign sleep = register_blob_i[8*MODE1 + 7 - SLEEP];

    for (genvar n = 0; n < NUM_CHANNELS; n++) begin : g_channel
        localparam int B = int'(BASE_REG) + 4*n;
        pwm_channel u_channel (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .on_l_i  (register_blob_i[8*B      +: 8]),
            .on_h_i  (register_blob_i[8*(B+1)  +: 8]),
            .off_l_i (register_blob_i[8*(B+2)  +: 8]),
            .off_h_i (register_blob_i[8*(B+3)  +: 8]),
            .wrap_i  (wrap),
            .cnt_i   (cnt_q),
            .level_o (raw_level[n])
        );
    end

    // Sleep and output-disable gate after the invert so they always force 0.
    assign final_level = (raw_level ^ {NUM_CHANNELS{invrt}}) & {NUM_CHANNELS{~sleep & ~oe_ni}};

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q          <= '0;
            pwm_o          <= '0;
            period_start_o <= 1'b0;
        end else begin
            cnt_q          <= counter_i;
            pwm_o          <= final_level;
            period_start_o <= wrap;
        end
    end

    logic unused_blob;
    assign unused_blob = ^register_blob_i;

endmodule
